// File: rtl/dma_copy_engine.sv
// Memory-to-memory copy engine: bus master that streams LEN bytes from SRC to DST
// in 1/2-byte beats, with the read of the next beat overlapping the current write.
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic [ADDR_WIDTH-1:0] dread_addr,
  input  logic [15:0]           dread_data,
  output logic [ADDR_WIDTH-1:0] dwrite_addr,
  output logic [15:0]           dwrite_data,
  output logic [1:0]            dwrite_en,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  remaining
);

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FINISH} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [LEN_WIDTH-1:0]    rd_rem_reg, rd_rem_next;
  logic [LEN_WIDTH-1:0]    wr_rem_reg, wr_rem_next;
  logic [LEN_WIDTH-1:0]    rem_reg, rem_next;
  logic                    pend_two_reg, pend_two_next;
  logic [ADDR_WIDTH-1:0]   last_rd_addr_reg;

  logic                    rd_two;
  logic [ADDR_WIDTH-1:0]   rd_step_a, wr_step_a;
  logic [LEN_WIDTH-1:0]    rd_step_l, wr_step_l, wr_left;

  assign rd_two    = (rd_rem_reg > LEN_WIDTH'(1));
  assign rd_step_a = rd_two ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
  assign rd_step_l = rd_two ? LEN_WIDTH'(2) : LEN_WIDTH'(1);
  assign wr_step_a = pend_two_reg ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
  assign wr_step_l = pend_two_reg ? LEN_WIDTH'(2) : LEN_WIDTH'(1);
  assign wr_left   = wr_rem_reg - wr_step_l;
  assign remaining = rem_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      rd_rem_reg       <= '0;
      wr_rem_reg       <= '0;
      rem_reg          <= '0;
      pend_two_reg     <= 1'b0;
      last_rd_addr_reg <= '0;
    end else begin
      state_reg        <= state_next;
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      rd_rem_reg       <= rd_rem_next;
      wr_rem_reg       <= wr_rem_next;
      rem_reg          <= rem_next;
      pend_two_reg     <= pend_two_next;
      last_rd_addr_reg <= dread_addr;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_rem_next   = rd_rem_reg;
    wr_rem_next   = wr_rem_reg;
    rem_next      = rem_reg;
    pend_two_next = pend_two_reg;
    dread_addr    = last_rd_addr_reg;
    dwrite_addr   = '0;
    dwrite_data   = '0;
    dwrite_en     = 2'b00;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          rd_ptr_next = src;
          wr_ptr_next = dst;
          rd_rem_next = len;
          wr_rem_next = len;
          rem_next    = len;
          state_next  = (len == '0) ? FINISH : FIRST;
        end
      end
      FIRST: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          dread_addr    = rd_ptr_reg;
          pend_two_next = rd_two;
          rd_ptr_next   = rd_ptr_reg + rd_step_a;
          rd_rem_next   = rd_rem_reg - rd_step_l;
          state_next    = STREAM;
        end
      end
      STREAM: begin
        busy        = 1'b1;
        dwrite_addr = wr_ptr_reg;
        dwrite_data = dread_data;
        if (abort) begin
          // Unwritten bytes stay visible in remaining after the abort.
          state_next = IDLE;
        end else begin
          dwrite_en   = pend_two_reg ? 2'b11 : 2'b01;
          wr_ptr_next = wr_ptr_reg + wr_step_a;
          wr_rem_next = wr_left;
          rem_next    = rem_reg - wr_step_l;
          if (rd_rem_reg != '0) begin
            dread_addr    = rd_ptr_reg;
            pend_two_next = rd_two;
            rd_ptr_next   = rd_ptr_reg + rd_step_a;
            rd_rem_next   = rd_rem_reg - rd_step_l;
          end
          state_next = (wr_left == '0) ? FINISH : STREAM;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: a byte-level memory bus model with
// same-cycle write forwarding, and a beat-by-beat reference copy model.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic [15:0] dread_addr, dwrite_addr, dwrite_data, remaining;
  logic [15:0] dread_data = '0;
  logic [1:0]  dwrite_en;
  logic        busy, done;

  dma_copy_engine #(.ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src(src), .dst(dst), .len(len),
    .dread_addr(dread_addr), .dread_data(dread_data),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  en;
    logic [15:0] rem;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference copy: each beat reads its bytes, then writes them, in order.
  task automatic model_xfer(input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input int e, input int max_beats);
    logic [15:0] rs, ws, rs1, ws1;
    logic [7:0]  b0, b1;
    int left, k, sz;
    exp_t x;
    rs = s; ws = d; left = int'(l); k = 0;
    while (left > 0 && k < max_beats) begin
      sz  = (left >= 2) ? 2 : 1;
      rs1 = rs + 16'd1;
      ws1 = ws + 16'd1;
      b0  = ref_mem[rs];
      b1  = ref_mem[rs1];
      ref_mem[ws] = b0;
      if (sz == 2) ref_mem[ws1] = b1;
      x.is_done = 1'b0; x.addr = ws; x.data = {b1, b0};
      x.en = (sz == 2) ? 2'b11 : 2'b01; x.rem = 16'(left); x.cyc = e + 1 + k;
      exp_q.push_back(x);
      rs = rs + 16'(sz); ws = ws + 16'(sz); left -= sz; k++;
    end
    if (left == 0) begin
      x.is_done = 1'b1; x.addr = '0; x.data = '0; x.en = 2'b00; x.rem = '0;
      x.cyc = (l == 16'd0) ? e : e + 1 + k;
      exp_q.push_back(x);
    end
  endtask

  // Bus model and monitor: writes land first, so a same-cycle read sees them.
  exp_t mh;
  logic [15:0] ra1, wa1;
  always @(negedge clk) begin
    if (reset) begin
      if (dwrite_en != 2'b00) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got en=%b addr=%h data=%h, required no write (cycle %0d)",
                   dwrite_en, dwrite_addr, dwrite_data, cyc);
        end else begin
          mh = exp_q.pop_front();
          chk("wr_addr", dwrite_addr, mh.addr);
          chk("wr_en", dwrite_en, mh.en);
          chk("wr_lo", dwrite_data[7:0], mh.data[7:0]);
          if (mh.en[1]) chk("wr_hi", dwrite_data[15:8], mh.data[15:8]);
          chk("wr_remaining", remaining, mh.rem);
          chk("wr_cycle", cyc, mh.cyc);
        end
        wa1 = dwrite_addr + 16'd1;
        if (dwrite_en[0]) mem[dwrite_addr] = dwrite_data[7:0];
        if (dwrite_en[1]) mem[wa1] = dwrite_data[15:8];
      end
      if (done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1, required 0 (cycle %0d)", cyc);
        end else begin
          mh = exp_q.pop_front();
          chk("done_cycle", cyc, mh.cyc);
          chk("done_remaining", remaining, mh.rem);
          chk("done_busy", busy, 1'b0);
        end
      end
    end
    ra1 = dread_addr + 16'd1;
    dread_data = {mem[ra1], mem[dread_addr]};
  end

  task automatic do_start(input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input int max_beats, output int e);
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    @(posedge clk);
    #1;
    e = cyc;
    start = 1'b0;
    model_xfer(s, d, l, e, max_beats);
    $display("start src=%h dst=%h len=%0d at cycle %0d", s, d, l, e);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, (n < 200), 1'b1);
    exp_q.delete();
  endtask

  int e;
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 5; i++) begin
      mem[16'h0100 + i] = 8'(8'h11 * (i + 1));
      ref_mem[16'h0100 + i] = mem[16'h0100 + i];
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wen", dwrite_en, 2'b00);
    chk("rst_raddr", dread_addr, 16'h0);
    chk("rst_waddr", dwrite_addr, 16'h0);
    chk("rst_wdata", dwrite_data, 16'h0);
    chk("rst_remaining", remaining, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    // Basic copy
    do_start(16'h0100, 16'h0200, 16'd5, 1000, e);
    @(negedge clk);
    chk("basic_first_busy", busy, 1'b1);
    chk("basic_first_wen", dwrite_en, 2'b00);
    wait_done("basic");
    chk("basic_mem", {mem[16'h0204], mem[16'h0203], mem[16'h0202], mem[16'h0201], mem[16'h0200]},
        {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});

    // Zero length
    do_start(16'h0300, 16'h0400, 16'd0, 1000, e);
    @(negedge clk);
    chk("zero_busy", busy, 1'b0);
    wait_done("zero");

    // Odd alignment and destination wrap
    do_start(16'h0011, 16'hFFFF, 16'd3, 1000, e);
    @(negedge clk);
    chk("odd_raddr0", dread_addr, 16'h0011);
    @(negedge clk);
    chk("odd_raddr1", dread_addr, 16'h0013);
    wait_done("odd");

    // Abort in the second STREAM cycle
    do_start(16'h0500, 16'h0600, 16'd8, 1, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_wen", dwrite_en, 2'b00);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_remaining", remaining, 16'd6);
    chk("abort_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    do_start(16'h0700, 16'h0800, 16'd4, 1000, e);
    wait_done("after_abort");

    // Start while busy is ignored
    do_start(16'h0900, 16'h0A00, 16'd10, 1000, e);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; src = 16'h1234; dst = 16'h5678; len = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");

    // Asynchronous reset mid-STREAM
    do_start(16'h0B00, 16'h0C00, 16'd12, 1000, e);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_wen", dwrite_en, 2'b00);
    chk("areset_busy", busy, 1'b0);
    chk("areset_raddr", dread_addr, 16'h0);
    chk("areset_waddr", dwrite_addr, 16'h0);
    chk("areset_remaining", remaining, 16'h0);
    exp_q.delete();
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("areset_idle_busy", busy, 1'b0);

    // Randomized transfers, some with overlapping forward copies
    for (int t = 0; t < 16; t++) begin
      logic [15:0] s, d, l;
      s = 16'($urandom);
      d = ($urandom_range(0, 3) == 0) ? s + 16'($urandom_range(1, 4)) : 16'($urandom);
      l = 16'($urandom_range(0, 24));
      do_start(s, d, l, 1000, e);
      wait_done("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Bus-master memory-to-memory copy engine; it is the initiator on the same split-byte data bus the I/O system responds to.
- Drives dread_addr/dwrite_addr/dwrite_data/dwrite_en and consumes dread_data.
- Copies LEN bytes from SRC to DST in 1- or 2-byte beats at one beat per cycle, reads pipelined against writes.
- Signals completion with a one-cycle done pulse, which the interrupt controller uses as an IRQ source.

Parameters:
ADDR_WIDTH, 16, width of bus addresses and of the src/dst counters; addresses wrap modulo 2^ADDR_WIDTH.
LEN_WIDTH, 16, width of the byte-count input and of the remaining-count output.

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
start  input  1  begin transfer; sampled only in IDLE
abort  input  1  cancel active transfer
src  input  ADDR_WIDTH  source byte address, latched on accepted start
dst  input  ADDR_WIDTH  destination byte address, latched on accepted start
len  input  LEN_WIDTH  byte count, latched on accepted start
dread_addr  output  ADDR_WIDTH  bus read address
dread_data  input  16  read data, valid the cycle after dread_addr is presented; [7:0]=byte at addr, [15:8]=byte at addr+1
dwrite_addr  output  ADDR_WIDTH  bus write address
dwrite_data  output  16  [7:0]→dwrite_addr, [15:8]→dwrite_addr+1
dwrite_en  output  2  byte enables; bit0 low byte, bit1 high byte
busy  output  1  transfer in progress
done  output  1  one-cycle pulse on normal completion
remaining  output  LEN_WIDTH  bytes not yet written

Behaviour:
- Reset (async, on reset=0): state IDLE. busy=0, done=0, dwrite_en=0, dread_addr=0, dwrite_addr=0, dwrite_data=0, remaining=0. All internal counters cleared. Reset mid-transfer abandons it with no further writes.
- States: IDLE, FIRST, STREAM, FINISH.
- Beat size: 2 if the relevant remaining count is ≥2, else 1.
- Beat sizes are independent of address parity; odd addresses use 2-byte beats as well.
- IDLE: on start=1, latch src→rd_ptr and dst→wr_ptr.
  - len→rd_rem, wr_rem and remaining.
  - If len=0, go to FINISH with no bus activity; otherwise go to FIRST.
  - start while not IDLE is ignored.
- FIRST (1 cycle): dread_addr=rd_ptr and dwrite_en=0.
  - Record rd beat size in pend_size; rd_ptr+=size, rd_rem-=size.
  - Go to STREAM.
- STREAM, write side: dwrite_addr=wr_ptr and dwrite_data=dread_data.
  - dwrite_en=2'b11 if pend_size=2, else 2'b01.
  - wr_ptr+=pend_size; wr_rem and remaining -=pend_size.
- STREAM, read side, same cycle: if rd_rem>0, dread_addr=rd_ptr; pend_size takes the new beat size; rd_ptr and rd_rem advance.
- STREAM exit: if the write in this cycle leaves wr_rem=0, go to FINISH; else stay in STREAM.
- FINISH (1 cycle): done=1, busy=0, dwrite_en=0, then IDLE.
- busy=1 in FIRST and STREAM only.
- dwrite_en is 0 in every state other than STREAM.
- dread_addr holds its last value when no read is issued.
- Latency: N=ceil(len/2) beats.
  - Start accepted at edge E; FIRST in cycle E+1; writes in cycles E+2..E+N+1; done in cycle E+N+2.
  - len=0 gives done in cycle E+1.
- abort=1 in FIRST or STREAM forces dwrite_en=0 combinationally in that cycle.
  - Next state is IDLE with no done pulse.
  - remaining holds the count of unwritten bytes.
  - abort in IDLE or FINISH has no effect; FINISH still pulses done.
- start and abort both high in IDLE: start wins (abort ignored in IDLE).
- Pointer wrap: 0xFFFF+1 → 0x0000, also for the high byte of a 2-byte beat at 0xFFFF (the bus handles it).
- Overlap: forward-copy semantics. The read of beat k+1 and the write of beat k share a cycle and the bus forwards same-address write data. dst>src with overlap gives repeated-pattern fill, which is defined behaviour.

Test Plan:
- Basic copy: src=0x0100, dst=0x0200, len=5, mem[0x100..0x104]=11..55.
  - Writes 0x2211@0x200 en=11, 0x4433@0x202 en=11, xx55@0x204 en=01.
  - done exactly 4 cycles after FIRST; remaining 5→3→1→0.
- Zero length: len=0 → no dwrite_en activity, busy stays 0, done pulses the cycle after start.
- Odd alignment and wrap: src=0x0011, dst=0xFFFF, len=3.
  - Writes at 0xFFFF en=11, then 0x0001 en=01; read addresses 0x0011 then 0x0013.
- Abort: len=8, abort asserted in the 2nd STREAM cycle.
  - Only the first beat is written, dwrite_en=0 in the abort cycle, no done, remaining=6, next start accepted.
- Start while busy: a second start with different src/dst/len mid-transfer is ignored; the original transfer completes unchanged.
- Async reset: drive reset=0 mid-STREAM without a clock edge.
  - Outputs go to reset values immediately; no writes after reset release until a new start.
